// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core on a single unified memory port; one FSM steps each instruction.
// Define MULTICYCLE_CORE_INSTRET_EN to build the retired-instruction counter (otherwise tied to 0).
module multicycle_core #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              MEM_AW   = XLEN
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_ready,
   output logic              illegal,
   output logic [31:0]       instret
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWRITE,
      MEMWB,
      EXECR,
      EXECI,
      ALUWB,
      BEQ,
      JAL,
      TRAP
   } state_t;

   state_t state;
   state_t next_state;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] old_pc;
   logic [31:0]     ir;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] mdr;
   logic [XLEN-1:0] rf [32];

   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] alu_rhs;
   logic [XLEN-1:0] alu_result;
   logic            slt_bit;
   logic [XLEN-1:0] addr_full;
   logic            rf_we;
   logic [XLEN-1:0] rf_wdata;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];

   assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
   assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   // x0 is hardwired through the read mux, so its storage entry never matters.
   assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

   always_comb begin
      alu_rhs    = (state == EXECI) ? imm_i : b;
      slt_bit    = $signed(a) < $signed(alu_rhs);
      alu_result = a + alu_rhs;
      case (funct3)
         3'b000: begin
            if ((state == EXECR) && ir[30]) begin
               alu_result = a - alu_rhs;
            end
         end
         3'b010:  alu_result = {{(XLEN-1){1'b0}}, slt_bit};
         3'b110:  alu_result = a | alu_rhs;
         3'b111:  alu_result = a & alu_rhs;
         default: alu_result = a + alu_rhs;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_full  = pc;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               next_state = DECODE;
            end
         end
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: next_state = MEMADR;
               OP_ALU:            next_state = EXECR;
               OP_ALUI:           next_state = EXECI;
               OP_BRANCH:         next_state = BEQ;
               OP_JAL:            next_state = JAL;
               default:           next_state = TRAP;
            endcase
         end
         MEMADR: begin
            next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            mem_req   = 1'b1;
            addr_full = alu_out;
            if (mem_ready) begin
               next_state = MEMWB;
            end
         end
         MEMWRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            addr_full = alu_out;
            if (mem_ready) begin
               next_state = FETCH;
            end
         end
         MEMWB:        next_state = FETCH;
         EXECR, EXECI: next_state = ALUWB;
         ALUWB:        next_state = FETCH;
         BEQ:          next_state = FETCH;
         JAL:          next_state = ALUWB;
         TRAP:         next_state = TRAP;
         default:      next_state = FETCH;
      endcase
      // Reset snaps state to FETCH, which would otherwise raise a request while reset is held.
      if (reset) begin
         mem_req = 1'b0;
      end
   end

   assign mem_addr  = addr_full[MEM_AW-1:0];
   assign mem_wdata = b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= RESET_PC;
         old_pc  <= '0;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         illegal <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (mem_ready) begin
                  ir     <= mem_rdata[31:0];
                  old_pc <= pc;
                  pc     <= pc + PC_STEP;
               end
            end
            DECODE: begin
               a       <= rs1_val;
               b       <= rs2_val;
               alu_out <= old_pc + imm_b;
            end
            MEMADR: begin
               alu_out <= a + ((opcode == OP_STORE) ? imm_s : imm_i);
            end
            MEMREAD: begin
               if (mem_ready) begin
                  mdr <= mem_rdata;
               end
            end
            EXECR, EXECI: begin
               alu_out <= alu_result;
            end
            BEQ: begin
               if (a == b) begin
                  pc <= alu_out;
               end
            end
            JAL: begin
               pc      <= old_pc + imm_j;
               alu_out <= old_pc + PC_STEP;
            end
            default: ;
         endcase
         if (next_state == TRAP) begin
            illegal <= 1'b1;
         end
      end
   end

   assign rf_we    = ((state == MEMWB) || (state == ALUWB)) && (rd != 5'd0);
   assign rf_wdata = (state == MEMWB) ? mdr : alu_out;

   always_ff @(posedge clk) begin
      if (rf_we) begin
         rf[rd] <= rf_wdata;
      end
   end

`ifdef MULTICYCLE_CORE_INSTRET_EN
   logic        retire;
   logic [31:0] instret_count;

   assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                   ((state == MEMWRITE) && mem_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_count <= 32'd0;
      end else if (retire) begin
         instret_count <= instret_count + 32'd1;
      end
   end

   assign instret = instret_count;
`else
   assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed example program, then random instructions checked
// cycle by cycle against an instruction-level reference model that also plays the memory.
module tb_multicycle_core;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        illegal;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   multicycle_core #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC),
      .MEM_AW   (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .illegal   (illegal),
      .instret   (instret)
   );

   always #5 clk = ~clk;

   typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_ANDI, K_ORI, K_SLTI,
                 K_LW, K_SW, K_BEQ, K_JAL, K_BAD} kind_t;

   typedef struct {
      kind_t       kind;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } instr_t;

   // Architectural reference state: registers, PC, data memory and retired count.
   logic [31:0] model_reg [32];
   bit          model_known [32];
   logic [31:0] model_pc;
   int unsigned model_retired;
   logic [31:0] dmem [bit [31:0]];

   function automatic logic [31:0] data_read(input logic [31:0] addr);
      if (dmem.exists(addr)) begin
         return dmem[addr];
      end
      return addr ^ 32'hA5A5_5A5A;
   endfunction

   function automatic instr_t mk(input kind_t k, input int rd, input int rs1, input int rs2, input int imm);
      instr_t i;
      i.kind = k;
      i.rd   = 5'(rd);
      i.rs1  = 5'(rs1);
      i.rs2  = 5'(rs2);
      i.imm  = imm;
      return i;
   endfunction

   function automatic logic [31:0] encode(input instr_t i);
      logic [31:0] im;
      im = i.imm;
      case (i.kind)
         K_ADD:   return {7'b0000000, i.rs2, i.rs1, 3'b000, i.rd, 7'b0110011};
         K_SUB:   return {7'b0100000, i.rs2, i.rs1, 3'b000, i.rd, 7'b0110011};
         K_SLT:   return {7'b0000000, i.rs2, i.rs1, 3'b010, i.rd, 7'b0110011};
         K_OR:    return {7'b0000000, i.rs2, i.rs1, 3'b110, i.rd, 7'b0110011};
         K_AND:   return {7'b0000000, i.rs2, i.rs1, 3'b111, i.rd, 7'b0110011};
         K_ADDI:  return {im[11:0], i.rs1, 3'b000, i.rd, 7'b0010011};
         K_SLTI:  return {im[11:0], i.rs1, 3'b010, i.rd, 7'b0010011};
         K_ORI:   return {im[11:0], i.rs1, 3'b110, i.rd, 7'b0010011};
         K_ANDI:  return {im[11:0], i.rs1, 3'b111, i.rd, 7'b0010011};
         K_LW:    return {im[11:0], i.rs1, 3'b010, i.rd, 7'b0000011};
         K_SW:    return {im[11:5], i.rs2, i.rs1, 3'b010, im[4:0], 7'b0100011};
         K_BEQ:   return {im[12], im[10:5], i.rs2, i.rs1, 3'b000, im[4:1], im[11], 7'b1100011};
         K_JAL:   return {im[20], im[10:1], im[11], im[19:12], i.rd, 7'b1101111};
         default: return 32'h0000_007F;
      endcase
   endfunction

   function automatic int zero_wait_latency(input kind_t k);
      case (k)
         K_LW:    return 5;
         K_SW:    return 4;
         K_BEQ:   return 3;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] exp_instret();
`ifdef MULTICYCLE_CORE_INSTRET_EN
      return model_retired;
`else
      return 32'd0;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ready, input logic [31:0] rdata);
      mem_ready = ready;
      mem_rdata = rdata;
      @(posedge clk);
      #1;
   endtask

   // A non-memory cycle: no request allowed, and ready noise must be ignored.
   task automatic idle_cycle();
      checkOutput("idle_req", 32'(mem_req), 32'd0);
      applyStimulus(1'($urandom_range(0, 1)), $urandom());
   endtask

   task automatic model_update(input instr_t ins, input logic [31:0] ea,
                               input logic [31:0] r1, input logic [31:0] r2);
      logic [31:0] res;
      logic [31:0] npc;
      bit          wr;
      res = '0;
      wr  = 1'b1;
      npc = model_pc + 32'd4;
      case (ins.kind)
         K_ADD:  res = r1 + r2;
         K_SUB:  res = r1 - r2;
         K_AND:  res = r1 & r2;
         K_OR:   res = r1 | r2;
         K_SLT:  res = {31'b0, $signed(r1) < $signed(r2)};
         K_ADDI: res = r1 + ins.imm;
         K_ANDI: res = r1 & ins.imm;
         K_ORI:  res = r1 | ins.imm;
         K_SLTI: res = {31'b0, $signed(r1) < $signed(ins.imm)};
         K_LW:   res = data_read(ea);
         K_SW: begin
            wr = 1'b0;
            dmem[ea] = r2;
         end
         K_BEQ: begin
            wr = 1'b0;
            if (r1 == r2) begin
               npc = model_pc + ins.imm;
            end
         end
         K_JAL: begin
            res = model_pc + 32'd4;
            npc = model_pc + ins.imm;
         end
         default: wr = 1'b0;
      endcase
      if (wr && (ins.rd != 5'd0)) begin
         model_reg[ins.rd]   = res;
         model_known[ins.rd] = 1'b1;
      end
      model_pc = npc;
      model_retired++;
   endtask

   // Runs one instruction; fs/ms are the wait cycles inserted on the fetch and data access.
   task automatic exec_one(input instr_t ins, input int fs, input int ms);
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] ea;
      bit          is_mem;
      int          pre;
      int          post;
      r1     = model_reg[ins.rs1];
      r2     = model_reg[ins.rs2];
      ea     = r1 + ins.imm;
      is_mem = (ins.kind == K_LW) || (ins.kind == K_SW);
      pre    = is_mem ? 2 : zero_wait_latency(ins.kind) - 1;
      post   = is_mem ? zero_wait_latency(ins.kind) - 4 : 0;
      for (int c = 0; c <= fs; c++) begin
         checkOutput("fetch_req", 32'(mem_req), 32'd1);
         checkOutput("fetch_we", 32'(mem_we), 32'd0);
         checkOutput("fetch_addr", mem_addr, model_pc);
         applyStimulus(c == fs, (c == fs) ? encode(ins) : $urandom());
      end
      for (int c = 0; c < pre; c++) begin
         idle_cycle();
      end
      if (is_mem) begin
         for (int c = 0; c <= ms; c++) begin
            checkOutput("data_req", 32'(mem_req), 32'd1);
            checkOutput("data_we", 32'(mem_we), (ins.kind == K_SW) ? 32'd1 : 32'd0);
            checkOutput("data_addr", mem_addr, ea);
            if (ins.kind == K_SW) begin
               checkOutput("store_data", mem_wdata, r2);
            end
            applyStimulus(c == ms, (c == ms) ? data_read(ea) : $urandom());
         end
      end
      for (int c = 0; c < post; c++) begin
         idle_cycle();
      end
      model_update(ins, ea, r1, r2);
      checkOutput("instret", instret, exp_instret());
      checkOutput("illegal_clear", 32'(illegal), 32'd0);
   endtask

   function automatic int pick_known();
      int r;
      do begin
         r = int'($urandom_range(0, 31));
      end while (!model_known[r]);
      return r;
   endfunction

   function automatic instr_t gen_random();
      int    sel;
      int    r1;
      int    r2;
      int    rd;
      kind_t k;
      sel = int'($urandom_range(0, 99));
      r1  = pick_known();
      r2  = pick_known();
      rd  = int'($urandom_range(0, 31));
      if (sel < 35) begin
         case ($urandom_range(0, 4))
            0:       k = K_ADD;
            1:       k = K_SUB;
            2:       k = K_AND;
            3:       k = K_OR;
            default: k = K_SLT;
         endcase
         return mk(k, rd, r1, r2, 0);
      end else if (sel < 62) begin
         case ($urandom_range(0, 3))
            0:       k = K_ADDI;
            1:       k = K_ANDI;
            2:       k = K_ORI;
            default: k = K_SLTI;
         endcase
         return mk(k, rd, r1, 0, int'($urandom_range(0, 4095)) - 2048);
      end else if (sel < 74) begin
         return mk(K_LW, rd, 0, 0, 4 * int'($urandom_range(16, 127)));
      end else if (sel < 88) begin
         return mk(K_SW, 0, 0, r2, 4 * int'($urandom_range(16, 127)));
      end else if (sel < 95) begin
         if ($urandom_range(0, 1) == 1) begin
            r2 = r1;
         end
         return mk(K_BEQ, 0, r1, r2, 4 * int'($urandom_range(0, 32)) - 64);
      end
      return mk(K_JAL, rd, 0, 0, 4 * int'($urandom_range(0, 64)) - 128);
   endfunction

   initial begin
      for (int r = 0; r < 32; r++) begin
         model_reg[r]   = '0;
         model_known[r] = (r == 0);
      end
      model_pc      = RESET_PC;
      model_retired = 0;
      reset         = 1'b1;
      mem_ready     = 1'b0;
      mem_rdata     = '0;

      $display("[TB] reset state");
      applyStimulus(1'b1, 32'h0000_0013);
      applyStimulus(1'b1, 32'h0000_0013);
      checkOutput("reset_req", 32'(mem_req), 32'd0);
      checkOutput("reset_illegal", 32'(illegal), 32'd0);
      checkOutput("reset_instret", instret, 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("first_fetch_req", 32'(mem_req), 32'd1);
      checkOutput("first_fetch_we", 32'(mem_we), 32'd0);
      checkOutput("first_fetch_addr", mem_addr, 32'h0000_0100);

      $display("[TB] directed program");
      exec_one(mk(K_ADDI, 1, 0, 0, 5), 0, 0);
      exec_one(mk(K_ADDI, 2, 0, 0, 7), 0, 0);
      exec_one(mk(K_ADD, 3, 1, 2, 0), 0, 0);
      exec_one(mk(K_SW, 0, 0, 3, 32'h40), 0, 0);
`ifdef MULTICYCLE_CORE_INSTRET_EN
      checkOutput("instret_after_4", instret, 32'd4);
`else
      checkOutput("instret_tied_zero", instret, 32'd0);
`endif
      exec_one(mk(K_LW, 4, 0, 0, 32'h40), 0, 3);
      exec_one(mk(K_SW, 0, 0, 4, 32'h44), 1, 2);
      exec_one(mk(K_JAL, 0, 0, 0, 32'h20 - 32'h118), 0, 0);
      checkOutput("jal_to_0x20", mem_addr, 32'h0000_0020);
      exec_one(mk(K_BEQ, 0, 1, 1, -8), 0, 0);
      checkOutput("beq_taken_fetch", mem_addr, 32'h0000_0018);
      exec_one(mk(K_JAL, 0, 0, 0, 8), 0, 0);
      exec_one(mk(K_BEQ, 0, 1, 2, -8), 2, 0);
      checkOutput("beq_not_taken_fetch", mem_addr, 32'h0000_0024);
      exec_one(mk(K_JAL, 0, 0, 0, 12), 0, 0);
      exec_one(mk(K_JAL, 1, 0, 0, 16), 0, 0);
      checkOutput("jal_target_fetch", mem_addr, 32'h0000_0040);
      exec_one(mk(K_ADDI, 0, 0, 0, 9), 0, 0);
      exec_one(mk(K_SW, 0, 0, 0, 32'h48), 0, 0);
      exec_one(mk(K_SW, 0, 0, 1, 32'h4C), 0, 1);

      $display("[TB] random instructions");
      for (int n = 0; n < 300; n++) begin
         exec_one(gen_random(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
      for (int r = 1; r < 32; r++) begin
         if (model_known[r]) begin
            exec_one(mk(K_SW, 0, 0, r, 32'h300 + 4 * r), 0, 0);
         end
      end

      $display("[TB] illegal opcode");
      for (int c = 0; c <= 1; c++) begin
         checkOutput("bad_fetch_addr", mem_addr, model_pc);
         applyStimulus(c == 1, encode(mk(K_BAD, 0, 0, 0, 0)));
      end
      idle_cycle();
      for (int c = 0; c < 6; c++) begin
         checkOutput("trap_illegal", 32'(illegal), 32'd1);
         checkOutput("trap_req", 32'(mem_req), 32'd0);
         applyStimulus(1'($urandom_range(0, 1)), $urandom());
      end
      checkOutput("trap_instret", instret, exp_instret());

      $display("[TB] reset recovery and reset during store");
      reset = 1'b1;
      #1;
      checkOutput("rst_trap_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_trap_req", 32'(mem_req), 32'd0);
      checkOutput("rst_trap_instret", instret, 32'd0);
      applyStimulus(1'b0, '0);
      reset = 1'b0;
      #1;
      model_pc      = RESET_PC;
      model_retired = 0;
      checkOutput("post_trap_fetch", mem_addr, RESET_PC);
      applyStimulus(1'b1, encode(mk(K_SW, 0, 0, 0, 32'h50)));
      idle_cycle();
      idle_cycle();
      checkOutput("abort_write_req", 32'(mem_req), 32'd1);
      checkOutput("abort_write_we", 32'(mem_we), 32'd1);
      checkOutput("abort_write_addr", mem_addr, 32'h0000_0050);
      applyStimulus(1'b0, $urandom());
      checkOutput("abort_write_held", mem_addr, 32'h0000_0050);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort_req_drop", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      exec_one(mk(K_LW, 5, 0, 0, 32'h50), 0, 1);
      exec_one(mk(K_SW, 0, 0, 5, 32'h54), 0, 0);
      exec_one(mk(K_SW, 0, 0, 3, 32'h58), 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
